// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: loader FSM state type and default chain/word sizes.
package ccff_loader_pkg;
    localparam int DEF_CHAIN_LEN = 8;
    localparam int DEF_WORD_W    = 8;
    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} ccff_ld_state_t;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready bitstream word handshake into the chain loader.
interface ccff_chain_loader_if
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    modport master (output cfg_data, cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: holds one bitstream word and presents it a bit at a time, LSB first.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              bit_out,
    output logic              last
);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    logic [WORD_W-1:0] word;
    logic [IW-1:0]     idx;
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= data;
            idx  <= '0;
        end else if (shift) begin
            idx <= idx + IW'(1);
        end
    end
    assign bit_out = word[idx];
    assign last    = idx == IW'(WORD_W - 1);
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words LSB-first into a ccff configuration chain.
// Define CCFF_READBACK_EN to collect the shifted-out chain tail into rdbk_data.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 abort,
    ccff_chain_loader_if.slave   cfg,
    output logic                 ccff_head,
    output logic                 ccff_en,
    input  logic                 ccff_tail,
`ifdef CCFF_READBACK_EN
    output logic [CHAIN_LEN-1:0] rdbk_data,
    output logic                 rdbk_valid,
`endif
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    ccff_ld_state_t state;
    logic [CW-1:0]  cnt;
    logic           word_bit, word_last, last_bit;
    assign last_bit = cnt == CW'(CHAIN_LEN - 1);
    ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .load     (state == WAIT_WORD && cfg.cfg_valid),
        .shift    (ccff_en),
        .data     (cfg.cfg_data),
        .bit_out  (word_bit),
        .last     (word_last)
    );
    // The chain bit count wins over the word boundary, so a partial final word is cut short.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= WAIT_WORD;
                    cnt   <= '0;
                end
                WAIT_WORD: if (cfg.cfg_valid) state <= SHIFT;
                SHIFT: begin
                    cnt   <= cnt + CW'(1);
                    state <= last_bit ? DONE : word_last ? WAIT_WORD : SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign cfg.cfg_ready = state == WAIT_WORD;
    assign ccff_en       = state == SHIFT;
    assign ccff_head     = ccff_en & word_bit;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
`ifdef CCFF_READBACK_EN
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            rdbk_data  <= '0;
            rdbk_valid <= 1'b0;
        end else begin
            if (ccff_en) rdbk_data <= {ccff_tail, rdbk_data[CHAIN_LEN-1:1]};
            if (state == IDLE && start && !abort) rdbk_valid <= 1'b0;
            else if (state == SHIFT && last_bit && !abort) rdbk_valid <= 1'b1;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized self-checking bench; one loader with WORD_W=8, one with WORD_W=3.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
    logic       clk = 0, rst = 0, start = 0, abort = 0, valid = 0, sel = 0;
    logic [7:0] wdata = '0;
    logic [7:0] chain = '0;
    logic       head8, en8, busy8, done8, head3, en3, busy3, done3;
    logic       head_s, en_s, busy_s, done_s, ready_s, tail;
`ifdef CCFF_READBACK_EN
    logic [7:0] rdbk8, rdbk3;
    logic       rv8, rv3;
`endif
    int         errors = 0, checks = 0, ncyc = 0, last_en = 0, done_cyc = 0, done_cnt = 0;
    bit         obs_q[$];
    logic [7:0] words[$];

    always #5 clk = ~clk;

    ccff_chain_loader_if #(.WORD_W(8)) if8 ();
    ccff_chain_loader_if #(.WORD_W(3)) if3 ();
    assign if8.cfg_valid = valid & ~sel;
    assign if8.cfg_data  = wdata;
    assign if3.cfg_valid = valid & sel;
    assign if3.cfg_data  = wdata[2:0];

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk(clk), .pReset(rst), .start(start & ~sel), .abort(abort), .cfg(if8),
        .ccff_head(head8), .ccff_en(en8), .ccff_tail(tail),
`ifdef CCFF_READBACK_EN
        .rdbk_data(rdbk8), .rdbk_valid(rv8),
`endif
        .busy(busy8), .done(done8)
    );
    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(3)) dut3 (
        .prog_clk(clk), .pReset(rst), .start(start & sel), .abort(abort), .cfg(if3),
        .ccff_head(head3), .ccff_en(en3), .ccff_tail(tail),
`ifdef CCFF_READBACK_EN
        .rdbk_data(rdbk3), .rdbk_valid(rv3),
`endif
        .busy(busy3), .done(done3)
    );

    assign head_s  = sel ? head3 : head8;
    assign en_s    = sel ? en3 : en8;
    assign busy_s  = sel ? busy3 : busy8;
    assign done_s  = sel ? done3 : done8;
    assign ready_s = sel ? if3.cfg_ready : if8.cfg_ready;
    assign tail    = chain[0];

    // Fabric chain of 8 flops, clocked only when the loader enables it.
    always @(posedge clk) if (en_s) chain <= {head_s, chain[7:1]};

    always @(negedge clk) begin
        ncyc++;
        if (en_s) begin
            obs_q.push_back(head_s);
            last_en = ncyc;
        end
        if (done_s) begin
            done_cnt++;
            done_cyc = ncyc;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Load the queued words; expectation is the LSB-first concatenation cut to 8 bits.
    task automatic do_load(input int ww, input int pre_stall, input int gap_max, input bit rand_start, input string name);
        bit         eq[$];
        logic [7:0] exp_bits, got_bits;
        int         nexp, wi, cyc;
        foreach (words[i]) for (int b = 0; b < ww; b++) eq.push_back(words[i][b]);
        for (int k = 0; k < 8; k++) exp_bits[k] = eq[k];
        nexp = (8 + ww - 1) / ww;
        obs_q.delete();
        done_cnt = 0;
        start = 1;
        tick;
        start = 0;
        for (int k = 0; k < pre_stall; k++) begin
            checks++;
            if (en_s !== 1'b0 || ready_s !== 1'b1) begin
                errors++;
                $display("FAIL %s stall: en=%b ready=%b, required en=0 ready=1", name, en_s, ready_s);
            end
            tick;
        end
        wi = 0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 300) begin
            valid = ready_s && (wi < words.size()) && ($urandom_range(0, gap_max) == 0);
            if (valid) begin
                wdata = words[wi];
                wi++;
            end
            start = rand_start && ($urandom_range(0, 3) == 0);
            tick;
            cyc++;
        end
        valid = 0;
        start = 0;
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
        end
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL %s shift_count: got %0d required 8", name, obs_q.size());
        end
        for (int k = 0; k < 8; k++) got_bits[k] = (k < obs_q.size()) ? obs_q[k] : 1'bx;
        checks++;
        if (got_bits !== exp_bits) begin
            errors++;
            $display("FAIL %s head_bits: got %b required %b", name, got_bits, exp_bits);
        end
        checks++;
        if (wi != nexp) begin
            errors++;
            $display("FAIL %s words_used: got %0d required %0d", name, wi, nexp);
        end
        checks++;
        if (done_cyc != last_en + 1) begin
            errors++;
            $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, last_en + 1);
        end
        tick;
        checks++;
        if (done_cnt != 1 || busy_s !== 1'b0 || done_s !== 1'b0 || ready_s !== 1'b0) begin
            errors++;
            $display("FAIL %s finish: done_pulses=%0d busy=%b done=%b ready=%b, required 1 0 0 0",
                     name, done_cnt, busy_s, done_s, ready_s);
        end
    endtask

    task automatic test_reset;
        logic [9:0] got;
        #1 rst = 1;
        #2;
        got = {busy8, en8, if8.cfg_ready, head8, done8, busy3, en3, if3.cfg_ready, head3, done3};
        checks++;
        if (got !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000000", got);
        end
`ifdef CCFF_READBACK_EN
        checks++;
        if ({rv8, rdbk8} !== 9'h0) begin
            errors++;
            $display("FAIL reset_rdbk: got %b_%h required 0_00", rv8, rdbk8);
        end
`endif
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_a5;
        sel = 0;
        words = '{8'hA5};
        do_load(8, 0, 0, 0, "a5");
    endtask

    task automatic test_narrow_words;
        sel = 1;
        words = '{8'h05, 8'h02, 8'h07};
        do_load(3, 0, 0, 0, "w3");
        sel = 0;
    endtask

    task automatic test_stall;
        sel = 0;
        words = '{8'($urandom)};
        do_load(8, 5, 0, 0, "stall");
    endtask

    task automatic test_abort;
        int cyc;
        sel = 0;
        obs_q.delete();
        done_cnt = 0;
        start = 1;
        tick;
        start = 0;
        valid = 1;
        wdata = 8'($urandom);
        tick;
        valid = 0;
        cyc = 0;
        while (obs_q.size() < 4 && cyc < 20) begin
            tick;
            cyc++;
        end
        abort = 1;
        tick;
        abort = 0;
        checks++;
        if (en_s !== 1'b0 || busy_s !== 1'b0 || obs_q.size() != 4) begin
            errors++;
            $display("FAIL abort_stop: en=%b busy=%b shifts=%0d, required 0 0 4", en_s, busy_s, obs_q.size());
        end
        repeat (3) tick;
        checks++;
        if (done_cnt != 0 || obs_q.size() != 4) begin
            errors++;
            $display("FAIL abort_nodone: done_pulses=%0d shifts=%0d, required 0 4", done_cnt, obs_q.size());
        end
`ifdef CCFF_READBACK_EN
        checks++;
        if (rv8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_rdbk_valid: got %b required 0", rv8);
        end
`endif
        start = 1;
        abort = 1;
        tick;
        start = 0;
        abort = 0;
        checks++;
        if (busy_s !== 1'b0 || ready_s !== 1'b0) begin
            errors++;
            $display("FAIL abort_over_start: busy=%b ready=%b required 0 0", busy_s, ready_s);
        end
        words = '{8'($urandom)};
        do_load(8, 0, 1, 0, "after_abort");
    endtask

    task automatic test_reset_mid_load;
        logic [4:0] got;
        sel = 0;
        start = 1;
        tick;
        start = 0;
        valid = 1;
        wdata = 8'($urandom);
        tick;
        valid = 0;
        tick;
        #2 rst = 1;
        #1;
        got = {busy_s, en_s, ready_s, head_s, done_s};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_shift: got %b required 00000", got);
        end
        tick;
        rst = 0;
        tick;
        words = '{8'($urandom)};
        do_load(8, 0, 1, 1, "start_ignored");
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            int ww;
            sel = 1'($urandom_range(0, 1));
            ww = sel ? 3 : 8;
            words.delete();
            for (int n = 0; n < (8 + ww - 1) / ww; n++) words.push_back(8'($urandom));
            do_load(ww, int'($urandom_range(0, 2)), 2, 1, $sformatf("random%0d", t));
        end
        sel = 0;
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback;
        sel = 0;
        words = '{8'h3C};
        do_load(8, 0, 0, 0, "rdbk_first");
        words = '{8'hC3};
        do_load(8, 0, 0, 0, "rdbk_second");
        checks++;
        if (rdbk8 !== 8'h3C || rv8 !== 1'b1) begin
            errors++;
            $display("FAIL readback: got data=%h valid=%b required 3c 1", rdbk8, rv8);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_a5;
        test_narrow_words;
        test_stall;
        test_abort;
        test_reset_mid_load;
        test_random;
`ifdef CCFF_READBACK_EN
        test_readback;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
